// File: rtl/wrr_pkg.sv
// Shared definitions for the weighted round-robin rx-queue scheduler.
// Holds the default geometry (queue count, maximum weight and the derived
// field widths), a ceiling-log2 helper used to size those fields, and the
// scheduler state encoding.
package wrr_pkg;

    // Ceiling log2; log2(1) = 0, log2(4) = 2, log2(5) = 3.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    localparam int NUM_QUEUES_DEF       = 4;
    localparam int MAX_WEIGHT_DEF       = 4;
    localparam int WEIGHT_WIDTH_DEF     = log2(MAX_WEIGHT_DEF) + 1;
    localparam int NUM_QUEUES_WIDTH_DEF = log2(NUM_QUEUES_DEF);

    // IDLE: searching; GRANT: grant offered; BUSY: packet in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } wrr_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority search.
// Ports:
//   mask  - candidate vector, bit i set = queue i may be picked
//   start - index examined first; the search wraps N-1 -> 0
//   hit   - at least one mask bit set
//   index - first set position at or after start (cyclically), 0 when no hit
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          hit,
    output logic [IW-1:0] index
);

    logic [IW-1:0] probe_s;

    // Walk the candidates starting at 'start', keep the first set one.
    always_comb begin
        hit     = 1'b0;
        index   = {IW{1'b0}};
        probe_s = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            probe_s = IW'((int'(start) + i) % N);
            if (!hit && mask[probe_s]) begin
                hit   = 1'b1;
                index = probe_s;
            end else begin
                hit   = hit;
            end
        end
    end

endmodule

// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler for rx-queue FIFOs.
// Each queue gets a turn of up to min(weight, MAX_WEIGHT) packets; a
// weight of 0 removes the queue from scheduling. A grant is offered
// (gnt_valid) until acknowledged (gnt_ack) or withdrawn by the queue going
// empty; an acknowledged packet is in flight (busy) until eop.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req         - per-queue non-empty flags
//   weight      - packed per-queue weight fields
//   gnt_ack     - grant accepted, packet read starts
//   eop         - last word of the in-flight packet written
//   gnt_valid   - grant offered (registered)
//   gnt_queue   - granted queue index (registered)
//   gnt_onehot  - one-hot of gnt_queue while granted or busy (registered)
//   busy        - packet in flight (registered)
module wrr_scheduler
    import wrr_pkg::*;
#(
    parameter int NUM_QUEUES       = NUM_QUEUES_DEF,
    parameter int MAX_WEIGHT       = MAX_WEIGHT_DEF,
    parameter int WEIGHT_WIDTH     = log2(MAX_WEIGHT) + 1,
    parameter int NUM_QUEUES_WIDTH = log2(NUM_QUEUES)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_QUEUES-1:0]              req,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weight,
    input  logic                               gnt_ack,
    input  logic                               eop,
    output logic                               gnt_valid,
    output logic [NUM_QUEUES_WIDTH-1:0]        gnt_queue,
    output logic [NUM_QUEUES-1:0]              gnt_onehot,
    output logic                               busy
);

    localparam int NQ = NUM_QUEUES;
    localparam int WW = WEIGHT_WIDTH;
    localparam int QW = NUM_QUEUES_WIDTH;

    wrr_state_e       state_r, state_s;
    logic [QW-1:0]    cur_queue_r, cur_queue_s;
    logic [WW-1:0]    credit_r, credit_s;
    logic [WW-1:0]    eff_weight_s [NQ];
    logic [NQ-1:0]    eligible_s;
    logic [QW-1:0]    start_s;
    logic             pick_hit_s;
    logic [QW-1:0]    pick_index_s;
    logic [NQ-1:0]    onehot_s;

    // Clamp each weight field and mark queues that may start a new turn.
    always_comb begin
        eff_weight_s = '{default: {WW{1'b0}}};
        eligible_s   = {NQ{1'b0}};
        for (int i = 0; i < NQ; i++) begin
            if (weight[i*WW +: WW] > WW'(MAX_WEIGHT)) begin
                eff_weight_s[i] = WW'(MAX_WEIGHT);
            end else begin
                eff_weight_s[i] = weight[i*WW +: WW];
            end
            eligible_s[i] = req[i] & (eff_weight_s[i] != {WW{1'b0}});
        end
    end

    // The search begins just after the current queue so it is examined last.
    always_comb begin
        if (cur_queue_r == QW'(NQ - 1)) begin
            start_s = {QW{1'b0}};
        end else begin
            start_s = cur_queue_r + QW'(1);
        end
    end

    rr_priority_pick #(
        .N  (NQ),
        .IW (QW)
    ) u_pick (
        .mask  (eligible_s),
        .start (start_s),
        .hit   (pick_hit_s),
        .index (pick_index_s)
    );

    // Next-state, next-queue and credit bookkeeping.
    // GRANT is only entered with credit >= 1, so the decrement cannot wrap.
    always_comb begin
        state_s     = state_r;
        cur_queue_s = cur_queue_r;
        credit_s    = credit_r;
        case (state_r)
            IDLE: begin
                if ((credit_r != {WW{1'b0}}) && req[cur_queue_r]) begin
                    state_s = GRANT;
                end else if (pick_hit_s) begin
                    state_s     = GRANT;
                    cur_queue_s = pick_index_s;
                    credit_s    = eff_weight_s[pick_index_s];
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (gnt_ack) begin
                    state_s  = BUSY;
                    credit_s = credit_r - WW'(1);
                end else if (!req[cur_queue_r]) begin
                    state_s  = IDLE;
                    credit_s = {WW{1'b0}};
                end else begin
                    state_s = GRANT;
                end
            end
            BUSY: begin
                if (eop) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s  = IDLE;
                credit_s = {WW{1'b0}};
            end
        endcase
    end

    // One-hot decode of the queue that the outputs will carry.
    always_comb begin
        onehot_s = {{(NQ-1){1'b0}}, 1'b1} << cur_queue_s;
    end

    // State and registered outputs; outputs mirror the next state so a
    // grant is visible the cycle after the decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cur_queue_r <= QW'(NQ - 1);
            credit_r    <= {WW{1'b0}};
            gnt_valid   <= 1'b0;
            gnt_queue   <= {QW{1'b0}};
            gnt_onehot  <= {NQ{1'b0}};
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            cur_queue_r <= cur_queue_s;
            credit_r    <= credit_s;
            gnt_valid   <= (state_s == GRANT);
            busy        <= (state_s == BUSY);
            if (state_s != IDLE) begin
                gnt_queue  <= cur_queue_s;
                gnt_onehot <= onehot_s;
            end else begin
                gnt_queue  <= gnt_queue;
                gnt_onehot <= {NQ{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_wrr_scheduler.sv
// Self-checking bench for wrr_scheduler: a turn-level reference model is
// compared against the outputs every cycle, directed scenarios pin grant
// orders to hand-computed sequences, and a randomized phase drives
// arbitrary req/weight/ack/eop/reset patterns.
module tb_wrr_scheduler;

    localparam int NQ   = 4;
    localparam int WW   = 3;
    localparam int QW   = 2;
    localparam int MAXW = 4;

    logic            clk;
    logic            reset;
    logic [NQ-1:0]   req;
    logic [NQ*WW-1:0] weight;
    logic            gnt_ack;
    logic            eop;
    logic            gnt_valid;
    logic [QW-1:0]   gnt_queue;
    logic [NQ-1:0]   gnt_onehot;
    logic            busy;

    wrr_scheduler #(
        .NUM_QUEUES       (NQ),
        .MAX_WEIGHT       (MAXW),
        .WEIGHT_WIDTH     (WW),
        .NUM_QUEUES_WIDTH (QW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .weight     (weight),
        .gnt_ack    (gnt_ack),
        .eop        (eop),
        .gnt_valid  (gnt_valid),
        .gnt_queue  (gnt_queue),
        .gnt_onehot (gnt_onehot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = nothing offered, 1 = grant offered,
    // 2 = packet in flight. m_q is the queue owning the current turn,
    // m_left the packets still allowed in that turn, m_shown the queue
    // the grant outputs must show.
    int m_phase = 0;
    int m_q     = NQ - 1;
    int m_left  = 0;
    int m_shown = 0;

    function automatic int eff_w(input int q);
        int w;
        w = int'((weight >> (WW * q)) & 12'd7);
        return (w > MAXW) ? MAXW : w;
    endfunction

    task automatic model_step();
        int  base;
        int  c;
        bit  found;
        if (reset === 1'b1) begin
            m_phase = 0; m_q = NQ - 1; m_left = 0; m_shown = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_left > 0 && req[m_q] === 1'b1) begin
                        m_phase = 1; m_shown = m_q;
                    end else begin
                        base  = m_q;
                        found = 1'b0;
                        for (int k = 1; k <= NQ; k++) begin
                            c = (base + k) % NQ;
                            if (!found && req[c] === 1'b1 && eff_w(c) > 0) begin
                                found = 1'b1;
                                m_q = c; m_left = eff_w(c); m_phase = 1; m_shown = c;
                            end
                        end
                    end
                end
                1: begin
                    if (gnt_ack === 1'b1) begin
                        m_left--; m_phase = 2;
                    end else if (req[m_q] !== 1'b1) begin
                        m_left = 0; m_phase = 0;
                    end
                end
                default: begin
                    if (eop === 1'b1) m_phase = 0;
                end
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    // Single compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt_valid", {31'd0, gnt_valid}, (m_phase == 1) ? 32'd1 : 32'd0);
            check("busy", {31'd0, busy}, (m_phase == 2) ? 32'd1 : 32'd0);
            check("gnt_queue", {30'd0, gnt_queue}, m_shown);
            check("gnt_onehot", {28'd0, gnt_onehot}, (m_phase != 0) ? (32'd1 << m_shown) : 32'd0);
        end
    end

    int got[$];
    int mgot[$];
    int exp_q[$];
    int eop_cnt;

    function automatic logic [NQ*WW-1:0] pack_w(input int w0, input int w1, input int w2, input int w3);
        return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; gnt_ack = 1'b0; eop = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Responder: ack every grant at once, pulse eop three cycles later.
    task automatic auto_cycle();
        @(negedge clk);
        gnt_ack = 1'b0;
        eop     = 1'b0;
        if (eop_cnt > 0) begin
            eop_cnt--;
            if (eop_cnt == 0) eop = 1'b1;
        end
        if (gnt_valid === 1'b1) begin
            gnt_ack = 1'b1;
            got.push_back(int'(gnt_queue));
            mgot.push_back(m_shown);
            eop_cnt = 3;
        end
    endtask

    task automatic run_order(input string name);
        got.delete(); mgot.delete(); eop_cnt = 0;
        for (int cyc = 0; cyc < 400 && got.size() < exp_q.size(); cyc++) auto_cycle();
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check(name, got[i], exp_q[i]);
            check({name, "_model"}, mgot[i], exp_q[i]);
        end
        gnt_ack = 1'b0; eop = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int cyc;
        cyc = 0;
        while (gnt_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_wait"}, {31'd0, gnt_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; weight = '0; gnt_ack = 1'b0; eop = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_queue", {30'd0, gnt_queue}, 32'd0);
        check("rst_onehot", {28'd0, gnt_onehot}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Equal unit weights: plain round robin starting at queue 0.
        do_reset();
        req = 4'b1111; weight = pack_w(1, 1, 1, 1);
        exp_q = '{0, 1, 2, 3, 0};
        run_order("order_unit");

        // Weighted pair.
        do_reset();
        req = 4'b0101; weight = pack_w(3, 0, 1, 0);
        exp_q = '{0, 0, 0, 2, 0, 0, 0, 2};
        run_order("order_w31");

        // Zero weight excludes queue 1.
        do_reset();
        req = 4'b1111; weight = pack_w(2, 0, 2, 2);
        exp_q = '{0, 0, 2, 2, 3, 3};
        run_order("order_w0");

        // Weight above MAX_WEIGHT clamps to 4.
        do_reset();
        req = 4'b0011; weight = pack_w(7, 1, 0, 0);
        exp_q = '{0, 0, 0, 0, 1};
        run_order("order_clamp");

        // Grant withdrawn before ack: moves on to queue 3.
        do_reset();
        req = 4'b0100; weight = pack_w(1, 1, 1, 1);
        wait_valid("withdraw");
        check("withdraw_q2", {30'd0, gnt_queue}, 32'd2);
        req = 4'b1000;
        @(negedge clk);
        check("withdraw_drop", {31'd0, gnt_valid}, 32'd0);
        check("withdraw_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("withdraw_next_v", {31'd0, gnt_valid}, 32'd1);
        check("withdraw_next_q", {30'd0, gnt_queue}, 32'd3);

        // Reset during BUSY aborts the turn; restart from queue 0.
        do_reset();
        req = 4'b0010; weight = pack_w(1, 1, 1, 1);
        wait_valid("rstbusy");
        gnt_ack = 1'b1;
        @(negedge clk);
        gnt_ack = 1'b0;
        check("rstbusy_busy", {31'd0, busy}, 32'd1);
        check("rstbusy_q1", {30'd0, gnt_queue}, 32'd1);
        reset = 1'b1; req = 4'b0011;
        @(negedge clk);
        reset = 1'b0;
        check("rstbusy_b0", {31'd0, busy}, 32'd0);
        check("rstbusy_v0", {31'd0, gnt_valid}, 32'd0);
        @(negedge clk);
        check("rstbusy_next_v", {31'd0, gnt_valid}, 32'd1);
        check("rstbusy_next_q", {30'd0, gnt_queue}, 32'd0);

        // Randomized traffic, including stray ack/eop and sporadic reset.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = NQ'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) weight = NQ*WW'($urandom);
            gnt_ack = ($urandom_range(0, 2) == 0);
            eop     = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        reset = 1'b0; gnt_ack = 1'b0; eop = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
